fifo_sc_param: RTL



---
 rtl/fifo_sc_pkg.sv | 27 ++
 rtl/fifo_sc_ram.sv | 37 +++
 rtl/fifo_sc_param.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_sc_pkg.sv
// rtl/fifo_sc_pkg.sv - shared constants, flag bundle and clog2 helper for the single-clock FIFO
package fifo_sc_pkg;

  localparam int FIFO_MIN_DEPTH = 4;

  typedef struct packed {
    logic empty;
    logic full;
    logic aempty;
    logic afull;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RESET = '{empty: 1'b1, full: 1'b0, aempty: 1'b1, afull: 1'b0};

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// rtl/fifo_sc_ram.sv - simple dual-port RAM, one write port and one registered read port
module fifo_sc_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset so the array can still map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sc_param.sv
// rtl/fifo_sc_param.sv - parametrised single-clock FIFO with thresholds, fill level, flush and error flags
// Define FIFO_SC_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module fifo_sc_param
  import fifo_sc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic                  Flush,
  input  logic [ADDR_W:0]       AEThresh,
  input  logic [ADDR_W:0]       AFThresh,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [ADDR_W:0]       Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  if (DEPTH < FIFO_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sc_param: DEPTH must be a power of 2 and at least FIFO_MIN_DEPTH");
  end

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  ovf_q, unf_q;
  logic                  wr_ok, rd_ok, ram_re, empty_d;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_ok = WrEn & ~flags_q.full;

`ifdef FIFO_SC_FWFT_EN
  logic ov_q, ov_d, ram_has_word;

  // The RAM read register doubles as the output register; Count includes its word.
  assign ram_has_word = (count_q != (ADDR_W+1)'(ov_q));
  assign rd_ok        = RdEn & ov_q;
  assign ram_re       = ram_has_word & (~ov_q | RdEn);
  assign ov_d         = ram_re | (ov_q & ~RdEn);
  assign empty_d      = ~ov_d;

  always_ff @(posedge Clock) begin
    if (!ResetN || Flush) begin
      ov_q <= 1'b0;
    end else begin
      ov_q <= ov_d;
    end
  end
`else
  assign rd_ok   = RdEn & ~flags_q.empty;
  assign ram_re  = rd_ok;
  assign empty_d = (count_d == '0);
`endif

  always_comb begin
    wr_ptr_d       = wr_ptr_q + ADDR_W'(wr_ok);
    rd_ptr_d       = rd_ptr_q + ADDR_W'(ram_re);
    count_d        = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    flags_d        = FIFO_FLAGS_RESET;
    flags_d.empty  = empty_d;
    flags_d.full   = (count_d == DEPTH_C);
    flags_d.aempty = (count_d <= AEThresh);
    flags_d.afull  = (count_d >= AFThresh);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN || Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FIFO_FLAGS_RESET;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_q | (WrEn & flags_q.full);
      unf_q    <= unf_q | (RdEn & flags_q.empty);
    end
  end

  // Flush gates both RAM ports so Q keeps its last value while pointers clear.
  fifo_sc_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk_i    (Clock),
    .resetn_i (ResetN),
    .we_i     (wr_ok & ~Flush & ResetN),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (Data),
    .re_i     (ram_re & ~Flush & ResetN),
    .raddr_i  (rd_ptr_q),
    .rdata_o  (ram_rdata)
  );

  assign Q           = ram_rdata;
  assign Empty       = flags_q.empty;
  assign Full        = flags_q.full;
  assign AlmostEmpty = flags_q.aempty;
  assign AlmostFull  = flags_q.afull;
  assign Count       = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;

endmodule
